// File: rtl/midi_decoder_pkg.sv
// -----------------------------------------------------------------------------
// midi_decoder_pkg
// Shared MIDI types for the channel-voice decoder and the synthesis pipeline:
//   note_status_t / note_change_t : note event handed to the synth voices
//   msg_type_t                    : upper nibble of a voice status byte
//   decoder_state_t               : parser states
//   byte_class_t + classify()     : combinational byte classifier
//   data_bytes()                  : data-byte count of a voice message type
// -----------------------------------------------------------------------------
package midi_decoder_pkg;

    typedef enum logic {
        STATUS_OFF = 1'b0,
        STATUS_ON  = 1'b1
    } note_status_t;

    typedef struct packed {
        note_status_t status;
        logic [6:0]   note_number;
        logic [6:0]   velocity;
    } note_change_t;

    typedef enum logic [3:0] {
        NOTE_OFF = 4'h8,
        NOTE_ON  = 4'h9,
        POLY_AT  = 4'hA,
        CC       = 4'hB,
        PROG     = 4'hC,
        CHAN_AT  = 4'hD,
        PITCH    = 4'hE
    } msg_type_t;

    typedef enum logic [1:0] {
        NO_STATUS,
        WAIT_D1,
        WAIT_D2
    } decoder_state_t;

    typedef enum logic [1:0] {
        BYTE_DATA,
        BYTE_VOICE,
        BYTE_SYS_COMMON,
        BYTE_REALTIME
    } byte_class_t;

    function automatic byte_class_t classify(input logic [7:0] b);
        if (!b[7])
            return BYTE_DATA;
        else if (b[7:4] != 4'hF)
            return BYTE_VOICE;
        else if (!b[3])
            return BYTE_SYS_COMMON;
        else
            return BYTE_REALTIME;
    endfunction

    function automatic logic [1:0] data_bytes(input msg_type_t t);
        return ((t == PROG) || (t == CHAN_AT)) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/midi_decoder.sv
// -----------------------------------------------------------------------------
// midi_decoder
// Byte-level MIDI channel-voice parser with running status, channel filter
// and real-time / system byte rejection. Emits note on/off and CC events.
//
// State | meaning
// ------+-----------------------------------------------------------------
// NO_STATUS | no running status; data bytes are dropped
// WAIT_D1   | running status valid, waiting for first data byte
// WAIT_D2   | first data byte latched, waiting for second data byte
//
// Ports:
//   clock_50_000_000 : system clock
//   reset_l          : asynchronous active-low reset
//   rx_byte/rx_valid : received byte and its one-cycle strobe
//   channel          : accepted MIDI channel (ignored when OMNI=1)
//   note/note_ready  : last note event and its one-cycle strobe
//   cc_number/cc_value/cc_ready : last CC event and its one-cycle strobe
// -----------------------------------------------------------------------------
module midi_decoder
    import midi_decoder_pkg::*;
#(
    parameter bit OMNI = 1'b0
) (
    input  logic         clock_50_000_000,
    input  logic         reset_l,
    input  logic [7:0]   rx_byte,
    input  logic         rx_valid,
    input  logic [3:0]   channel,
    output note_change_t note,
    output logic         note_ready,
    output logic [6:0]   cc_number,
    output logic [6:0]   cc_value,
    output logic         cc_ready
);

    decoder_state_t state, next_state;
    logic [7:0]     run_status, next_status;
    logic [6:0]     d1, next_d1;
    logic           complete;
    msg_type_t      msg_type;
    logic           chan_ok;

    // run_status is only ever loaded with 8x..Ex, so the cast is always a
    // legal member whenever a message can complete.
    assign msg_type = msg_type_t'(run_status[7:4]);
    assign chan_ok  = OMNI || (run_status[3:0] == channel);

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state      <= NO_STATUS;
            run_status <= 8'h00;
            d1         <= 7'h00;
        end else begin
            state      <= next_state;
            run_status <= next_status;
            d1         <= next_d1;
        end
    end

    always_comb begin
        next_state  = state;
        next_status = run_status;
        next_d1     = d1;
        complete    = 1'b0;
        if (rx_valid) begin
            unique case (classify(rx_byte))
                BYTE_VOICE: begin
                    next_status = rx_byte;
                    next_state  = WAIT_D1;
                end
                BYTE_SYS_COMMON: begin
                    next_status = 8'h00;
                    next_state  = NO_STATUS;
                end
                BYTE_REALTIME: ;
                BYTE_DATA: begin
                    unique case (state)
                        NO_STATUS: ;
                        WAIT_D1: begin
                            next_d1 = rx_byte[6:0];
                            if (data_bytes(msg_type) == 2'd1)
                                complete = 1'b1;
                            else
                                next_state = WAIT_D2;
                        end
                        WAIT_D2: begin
                            complete   = 1'b1;
                            next_state = WAIT_D1;
                        end
                        default: next_state = NO_STATUS;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // On completion the second data byte is still on rx_byte, so it is used
    // directly instead of being latched.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            note       <= '{status: STATUS_OFF, note_number: 7'h00, velocity: 7'h00};
            note_ready <= 1'b0;
            cc_number  <= 7'h00;
            cc_value   <= 7'h00;
            cc_ready   <= 1'b0;
        end else begin
            note_ready <= 1'b0;
            cc_ready   <= 1'b0;
            if (complete && chan_ok) begin
                case (msg_type)
                    NOTE_ON: begin
                        note_ready <= 1'b1;
                        if (rx_byte[6:0] != 7'h00)
                            note <= '{status: STATUS_ON, note_number: d1, velocity: rx_byte[6:0]};
                        else
                            note <= '{status: STATUS_OFF, note_number: d1, velocity: 7'h00};
                    end
                    NOTE_OFF: begin
                        note_ready <= 1'b1;
                        note       <= '{status: STATUS_OFF, note_number: d1, velocity: rx_byte[6:0]};
                    end
                    CC: begin
                        cc_ready  <= 1'b1;
                        cc_number <= d1;
                        cc_value  <= rx_byte[6:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
